// File: rtl/lsu_axi_master_pkg.sv
// lsu_axi_master_pkg
// Shared definitions for the LSU AXI initiator: FSM state encoding, access
// size codes, AXI response codes and the misalignment helper.
package lsu_axi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // An access is misaligned when it would cross the 8-byte lane boundary.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] end_s;
    end_s = {1'b0, off} + (4'd1 << size);
    return (end_s > 4'd8);
  endfunction

endpackage

// File: rtl/lsu_axi_master_lane_align.sv
// lsu_lane_align
// Combinational byte-lane steering for a 64-bit bus.
//   off, size        : byte offset within the dword and access size code
//   is_signed        : sign-extend load data when set
//   wdata / rdata    : right-aligned store data / raw bus read data
//   strb / wdata_sh  : write strobe and lane-shifted store data
//   rdata_ext        : extracted and extended load data
module lsu_lane_align
  import lsu_axi_master_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  strb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);

  logic [7:0]  mask_s;
  logic [63:0] rdata_sh_s;

  // Store side: byte mask for the size, moved up to the addressed lane.
  always_comb begin
    mask_s = 8'h00;
    case (size)
      SIZE_B:  mask_s = 8'h01;
      SIZE_H:  mask_s = 8'h03;
      SIZE_W:  mask_s = 8'h0F;
      SIZE_D:  mask_s = 8'hFF;
      default: mask_s = 8'h00;
    endcase
    strb     = mask_s << off;
    wdata_sh = wdata << {off, 3'b000};
  end

  // Load side: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_sh_s = rdata >> {off, 3'b000};
    rdata_ext  = 64'd0;
    case (size)
      SIZE_B:  rdata_ext = {{56{is_signed & rdata_sh_s[7]}},  rdata_sh_s[7:0]};
      SIZE_H:  rdata_ext = {{48{is_signed & rdata_sh_s[15]}}, rdata_sh_s[15:0]};
      SIZE_W:  rdata_ext = {{32{is_signed & rdata_sh_s[31]}}, rdata_sh_s[31:0]};
      SIZE_D:  rdata_ext = rdata_sh_s;
      default: rdata_ext = rdata_sh_s;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// lsu_axi_master
// Turns single LSU load/store requests into AXI-lite style transactions,
// one outstanding at a time.
//   clk, rst           : clock, asynchronous active-high reset
//   req_*              : LSU request handshake and payload
//   rsp_*              : one-cycle completion pulse with data/error
//   axi_aw/w/b/ar/r_*  : single-beat AXI initiator channels
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              axi_aw_valid_o,
  input  logic              axi_aw_ready_i,
  output logic [ADDR_W-1:0] axi_aw_addr_o,
  output logic              axi_w_valid_o,
  input  logic              axi_w_ready_i,
  output logic [DATA_W-1:0] axi_w_data_o,
  output logic [7:0]        axi_w_strb_o,
  input  logic              axi_b_valid_i,
  output logic              axi_b_ready_o,
  input  logic [1:0]        axi_b_resp_i,
  output logic              axi_ar_valid_o,
  input  logic              axi_ar_ready_i,
  output logic [ADDR_W-1:0] axi_ar_addr_o,
  input  logic              axi_r_valid_i,
  output logic              axi_r_ready_o,
  input  logic [1:0]        axi_r_resp_i,
  input  logic [DATA_W-1:0] axi_r_data_i
);

  lsu_state_e  state_r;
  logic [2:0]  off_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        aw_done_r;
  logic        w_done_r;

  logic [2:0]  align_off_s;
  logic [1:0]  align_size_s;
  logic [7:0]  strb_s;
  logic [63:0] wdata_sh_s;
  logic [63:0] load_ext_s;
  logic        aw_hs_s;
  logic        w_hs_s;

  // In IDLE the aligner sees the incoming request (store data is captured on
  // accept); afterwards it sees the latched load offset/size.
  always_comb begin
    if (state_r == ST_IDLE) begin
      align_off_s  = req_addr[2:0];
      align_size_s = req_size;
    end else begin
      align_off_s  = off_r;
      align_size_s = size_r;
    end
  end

  // Write-channel handshakes as seen in the current cycle.
  always_comb begin
    aw_hs_s = axi_aw_valid_o & axi_aw_ready_i;
    w_hs_s  = axi_w_valid_o & axi_w_ready_i;
  end

  lsu_lane_align u_align (
    .off       (align_off_s),
    .size      (align_size_s),
    .is_signed (signed_r),
    .wdata     (req_wdata),
    .rdata     (axi_r_data_i),
    .strb      (strb_s),
    .wdata_sh  (wdata_sh_s),
    .rdata_ext (load_ext_s)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      off_r          <= 3'd0;
      size_r         <= 2'd0;
      signed_r       <= 1'b0;
      aw_done_r      <= 1'b0;
      w_done_r       <= 1'b0;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      axi_aw_valid_o <= 1'b0;
      axi_aw_addr_o  <= '0;
      axi_w_valid_o  <= 1'b0;
      axi_w_data_o   <= '0;
      axi_w_strb_o   <= 8'h00;
      axi_b_ready_o  <= 1'b0;
      axi_ar_valid_o <= 1'b0;
      axi_ar_addr_o  <= '0;
      axi_r_ready_o  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            off_r     <= req_addr[2:0];
            size_r    <= req_size;
            signed_r  <= req_signed;
            if (is_misaligned(req_addr[2:0], req_size)) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state_r   <= ST_DONE;
            end else if (req_wen) begin
              axi_aw_valid_o <= 1'b1;
              axi_aw_addr_o  <= req_addr;
              axi_w_valid_o  <= 1'b1;
              axi_w_data_o   <= wdata_sh_s;
              axi_w_strb_o   <= strb_s;
              aw_done_r      <= 1'b0;
              w_done_r       <= 1'b0;
              state_r        <= ST_WR_REQ;
            end else begin
              axi_ar_valid_o <= 1'b1;
              axi_ar_addr_o  <= req_addr;
              state_r        <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (axi_ar_ready_i) begin
            axi_ar_valid_o <= 1'b0;
            axi_r_ready_o  <= 1'b1;
            state_r        <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (axi_r_valid_i) begin
            axi_r_ready_o <= 1'b0;
            rsp_valid     <= 1'b1;
            if (axi_r_resp_i != AXI_RESP_OKAY) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              rsp_err   <= 1'b0;
              rsp_rdata <= load_ext_s;
            end
            state_r <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          // Each channel retires independently; move on once both have.
          if (aw_hs_s) begin
            axi_aw_valid_o <= 1'b0;
            aw_done_r      <= 1'b1;
          end
          if (w_hs_s) begin
            axi_w_valid_o <= 1'b0;
            w_done_r      <= 1'b1;
          end
          if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
            axi_b_ready_o <= 1'b1;
            state_r       <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi_b_valid_i) begin
            axi_b_ready_o <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= (axi_b_resp_i != AXI_RESP_OKAY);
            rsp_rdata     <= '0;
            state_r       <= ST_DONE;
          end
        end
        ST_DONE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r        <= ST_IDLE;
          req_ready      <= 1'b1;
          rsp_valid      <= 1'b0;
          axi_aw_valid_o <= 1'b0;
          axi_w_valid_o  <= 1'b0;
          axi_b_ready_o  <= 1'b0;
          axi_ar_valid_o <= 1'b0;
          axi_r_ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master
// Directed bench for lsu_axi_master: inputs change and outputs are sampled
// on the falling clock edge, away from the active rising edge.
module tb_lsu_axi_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        aw_valid, aw_ready;
  logic [63:0] aw_addr;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic        r_valid, r_ready;
  logic [1:0]  r_resp;
  logic [63:0] r_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  lsu_axi_master #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wen        (req_wen),
    .req_addr       (req_addr),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .axi_aw_valid_o (aw_valid),
    .axi_aw_ready_i (aw_ready),
    .axi_aw_addr_o  (aw_addr),
    .axi_w_valid_o  (w_valid),
    .axi_w_ready_i  (w_ready),
    .axi_w_data_o   (w_data),
    .axi_w_strb_o   (w_strb),
    .axi_b_valid_i  (b_valid),
    .axi_b_ready_o  (b_ready),
    .axi_b_resp_i   (b_resp),
    .axi_ar_valid_o (ar_valid),
    .axi_ar_ready_i (ar_ready),
    .axi_ar_addr_o  (ar_addr),
    .axi_r_valid_i  (r_valid),
    .axi_r_ready_o  (r_ready),
    .axi_r_resp_i   (r_resp),
    .axi_r_data_i   (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                     input logic sgn, input logic [63:0] wdata);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_wdata  = wdata;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = 64'd0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'd0;
    ar_ready = 1'b0; r_valid = 1'b0; r_resp = 2'd0; r_data = 64'd0;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_ar_valid",  {63'd0, ar_valid},  64'd0);
    chk("rst_aw_valid",  {63'd0, aw_valid},  64'd0);
    chk("rst_w_strb",    {56'd0, w_strb},    64'd0);
    rst = 1'b0;

    // Signed word load at offset 4
    @(negedge clk);
    req(1'b0, 64'h8000_0004, 2'd2, 1'b1, 64'd0);
    ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'd0; r_data = 64'h8765_4321_1234_5678;
    @(negedge clk); req_valid = 1'b0;
    chk("ldw_c1_ar_valid", {63'd0, ar_valid}, 64'd1);
    chk("ldw_c1_ar_addr",  ar_addr, 64'h8000_0004);
    chk("ldw_c1_req_ready", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    chk("ldw_c2_r_ready",  {63'd0, r_ready},  64'd1);
    chk("ldw_c2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("ldw_c3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("ldw_c3_rdata", rsp_rdata, 64'hFFFF_FFFF_8765_4321);
    chk("ldw_c3_err",   {63'd0, rsp_err}, 64'd0);
    r_valid = 1'b0; ar_ready = 1'b0;
    @(negedge clk);
    chk("ldw_c4_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("ldw_c4_req_ready", {63'd0, req_ready}, 64'd1);

    // Byte store at offset 3
    req(1'b1, 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_0000_00AB);
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'd0;
    @(negedge clk); req_valid = 1'b0;
    chk("stb_aw_valid", {63'd0, aw_valid}, 64'd1);
    chk("stb_w_valid",  {63'd0, w_valid},  64'd1);
    chk("stb_aw_addr",  aw_addr, 64'h8000_0003);
    chk("stb_w_strb",   {56'd0, w_strb}, 64'h08);
    chk("stb_w_data",   w_data, 64'h0000_0000_AB00_0000);
    @(negedge clk);
    chk("stb_aw_drop",  {63'd0, aw_valid}, 64'd0);
    chk("stb_w_drop",   {63'd0, w_valid},  64'd0);
    chk("stb_b_ready",  {63'd0, b_ready},  64'd1);
    @(negedge clk);
    chk("stb_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("stb_rsp_err",   {63'd0, rsp_err},   64'd0);
    chk("stb_rsp_rdata", rsp_rdata, 64'd0);
    b_valid = 1'b0;
    @(negedge clk);
    chk("stb_rsp_end", {63'd0, rsp_valid}, 64'd0);

    // Decoupled write: AW accepted at once, W held off for three cycles
    req(1'b1, 64'h8000_0012, 2'd1, 1'b0, 64'h0000_0000_0000_1234);
    aw_ready = 1'b1; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'd0;
    @(negedge clk); req_valid = 1'b0;
    chk("dec_c1_aw_valid", {63'd0, aw_valid}, 64'd1);
    chk("dec_c1_w_valid",  {63'd0, w_valid},  64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dec_aw_low",    {63'd0, aw_valid},  64'd0);
      chk("dec_w_held",    {63'd0, w_valid},   64'd1);
      chk("dec_w_data",    w_data, 64'h0000_0000_1234_0000);
      chk("dec_w_strb",    {56'd0, w_strb}, 64'h0C);
      chk("dec_b_ready_lo", {63'd0, b_ready},  64'd0);
      chk("dec_rsp_lo",    {63'd0, rsp_valid}, 64'd0);
    end
    w_ready = 1'b1;
    @(negedge clk);
    chk("dec_w_drop",  {63'd0, w_valid}, 64'd0);
    chk("dec_b_ready", {63'd0, b_ready}, 64'd1);
    chk("dec_rsp_lo2", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    chk("dec_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("dec_rsp_err",   {63'd0, rsp_err},   64'd0);
    b_valid = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    chk("dec_rsp_once", {63'd0, rsp_valid}, 64'd0);

    // Half-word load with SLVERR
    req(1'b0, 64'h8000_0002, 2'd1, 1'b0, 64'd0);
    ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'b10; r_data = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("err_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("err_rsp_err",   {63'd0, rsp_err},   64'd1);
    chk("err_rsp_rdata", rsp_rdata, 64'd0);
    r_valid = 1'b0; r_resp = 2'd0;
    @(negedge clk);

    // Misaligned word load: no AR traffic, response next cycle
    req(1'b0, 64'h8000_0006, 2'd2, 1'b0, 64'd0);
    @(negedge clk); req_valid = 1'b0;
    chk("mis_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("mis_rsp_err",   {63'd0, rsp_err},   64'd1);
    chk("mis_ar_valid",  {63'd0, ar_valid},  64'd0);
    @(negedge clk);
    chk("mis_ar_valid2", {63'd0, ar_valid},  64'd0);
    chk("mis_rsp_end",   {63'd0, rsp_valid}, 64'd0);
    chk("mis_req_ready", {63'd0, req_ready}, 64'd1);

    // Signed byte load from the top lane
    req(1'b0, 64'h8000_0007, 2'd0, 1'b1, 64'd0);
    ar_ready = 1'b1; r_valid = 1'b1; r_resp = 2'd0; r_data = 64'h8011_2233_4455_6677;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ldb7_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("ldb7_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    r_valid = 1'b0;
    @(negedge clk);

    // Reset asserted while waiting in RD_DATA
    req(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0);
    ar_ready = 1'b1; r_valid = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("rmr_r_ready_before", {63'd0, r_ready}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmr_r_ready",   {63'd0, r_ready},   64'd0);
    chk("rmr_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rmr_ar_addr",   ar_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmr_req_ready_rel", {63'd0, req_ready}, 64'd1);
    req(1'b0, 64'h8000_0000, 2'd3, 1'b0, 64'd0);
    r_valid = 1'b1; r_resp = 2'd0; r_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); req_valid = 1'b0;
    chk("rmr_ld_ar_addr", ar_addr, 64'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    chk("rmr_ld_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rmr_ld_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
    chk("rmr_ld_err",   {63'd0, rsp_err}, 64'd0);
    r_valid = 1'b0; ar_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
